// File: rtl/mem_responder_sram_pkg.sv
// Shared types and constants for the mask-based memory responder.
// Contents: FSM state enum, bus widths, and a byte-lane expansion helper.
package mem_responder_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Turn a 4-bit byte-lane mask into a 32-bit bit mask (lane i -> bits 8i+7:8i).
  function automatic logic [MEM_DATA_W-1:0] lane_expand(input logic [MEM_MASK_W-1:0] m);
    logic [MEM_DATA_W-1:0] r;
    r = {MEM_DATA_W{1'b0}};
    for (int i = 0; i < MEM_MASK_W; i++) begin
      r[8*i +: 8] = m[i] ? 8'hFF : 8'h00;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_responder_sram_if.sv
// Mask-based 32-bit memory link between an initiator and a memory responder.
// master: initiator side (drives addr/rmask/wmask/wdata, sees rdata/resp/error).
// slave : memory side (the responder).
interface mem_responder_sram_if;
  import mem_responder_pkg::*;

  logic [MEM_ADDR_W-1:0] addr;
  logic [MEM_MASK_W-1:0] rmask;
  logic [MEM_MASK_W-1:0] wmask;
  logic [MEM_DATA_W-1:0] wdata;
  logic [MEM_DATA_W-1:0] rdata;
  logic                  resp;
  logic                  error;

  modport master (output addr, rmask, wmask, wdata, input rdata, resp, error);
  modport slave  (input addr, rmask, wmask, wdata, output rdata, resp, error);

endinterface

// File: rtl/mem_responder_sram_array.sv
// Word-addressed, byte-writable single-port storage for the memory responder.
// Ports: clk, rst (async active-low, clears only the read register),
//        idx (word index shared by read and write), re/re_lanes (registered
//        read, lanes not enabled return zero), we (per-lane write enable),
//        wdata (write data), q (registered read data, zero when re is low).
// Storage contents have no reset and survive rst.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic                  re,
  input  logic [MEM_MASK_W-1:0] re_lanes,
  input  logic [MEM_MASK_W-1:0] we,
  input  logic [MEM_DATA_W-1:0] wdata,
  output logic [MEM_DATA_W-1:0] q
);

  logic [MEM_DATA_W-1:0] mem_r [0:(1<<DEPTH_LOG2)-1];
  logic [MEM_DATA_W-1:0] q_r;

  // Byte-enabled write into the storage array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MEM_MASK_W; i++) begin
      if (we[i]) begin
        mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register: holds masked data for one cycle after a read, zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= {MEM_DATA_W{1'b0}};
    end else begin
      q_r <= re ? (mem_r[idx] & lane_expand(re_lanes)) : {MEM_DATA_W{1'b0}};
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mem_responder_sram.sv
// Memory-side responder for the mask-based memory link: fixed-latency,
// byte-writable SRAM with a sticky initiator protocol checker.
// Ports: clk, rst (async active-low), bus (slave modport of the link).
// A request seen in IDLE in cycle T produces a one-cycle resp in T+LATENCY,
// always completing from the values latched at acceptance.
module mem_responder_sram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input logic                 clk,
  input logic                 rst,
  mem_responder_sram_if.slave bus
);

  state_t                state_r;
  logic [3:0]            cnt_r;
  logic [MEM_ADDR_W-1:0] addr_r;
  logic [MEM_MASK_W-1:0] rmask_r;
  logic [MEM_MASK_W-1:0] wmask_r;
  logic [MEM_DATA_W-1:0] wdata_r;
  logic                  resp_r;
  logic                  error_r;

  logic                  req_s;
  logic                  viol_s;
  logic                  diff_s;
  logic                  err_set_s;
  logic                  go_resp_s;
  logic [MEM_MASK_W-1:0] rd_lanes_s;
  logic [MEM_MASK_W-1:0] we_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [MEM_DATA_W-1:0] rdata_s;

  // Next-step decode: request detect, protocol checks, read/write steering.
  always_comb begin
    req_s  = (bus.rmask != 4'h0) || (bus.wmask != 4'h0);
    // Mixed read/write, misaligned, or beyond the array.
    viol_s = ((bus.rmask != 4'h0) && (bus.wmask != 4'h0)) ||
             (bus.addr[1:0] != 2'b00) ||
             ((bus.addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    diff_s = (bus.addr != addr_r) || (bus.rmask != rmask_r) ||
             (bus.wmask != wmask_r) || (bus.wdata != wdata_r);
    err_set_s  = 1'b0;
    go_resp_s  = 1'b0;
    rd_lanes_s = 4'h0;
    idx_s      = addr_r[DEPTH_LOG2+1:2];
    case (state_r)
      IDLE: begin
        err_set_s  = req_s && viol_s;
        go_resp_s  = req_s && (LATENCY == 1);
        // A mixed request behaves as a write, so its read lanes are dropped.
        rd_lanes_s = (bus.wmask != 4'h0) ? 4'h0 : bus.rmask;
        idx_s      = bus.addr[DEPTH_LOG2+1:2];
      end
      WAIT: begin
        err_set_s  = viol_s || diff_s;
        go_resp_s  = (cnt_r == 4'd1);
        rd_lanes_s = (wmask_r != 4'h0) ? 4'h0 : rmask_r;
      end
      RESP: begin
        err_set_s = viol_s || diff_s;
      end
      default: begin
        err_set_s = 1'b0;
      end
    endcase
    // Writes commit on the edge that ends the RESP cycle.
    we_s = (state_r == RESP) ? wmask_r : 4'h0;
  end

  // Transaction FSM with latency counter, request latches and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= 32'h0;
      rmask_r <= 4'h0;
      wmask_r <= 4'h0;
      wdata_r <= 32'h0;
      resp_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      if (err_set_s) begin
        error_r <= 1'b1;
      end
      resp_r <= go_resp_s;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            addr_r  <= bus.addr;
            rmask_r <= bus.rmask;
            wmask_r <= bus.wmask;
            wdata_r <= bus.wdata;
            cnt_r   <= 4'(LATENCY - 1);
            state_r <= go_resp_s ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (go_resp_s) begin
            state_r <= RESP;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  mem_responder_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx_s),
    .re       (go_resp_s),
    .re_lanes (rd_lanes_s),
    .we       (we_s),
    .wdata    (wdata_r),
    .q        (rdata_s)
  );

  assign bus.rdata = rdata_s;
  assign bus.resp  = resp_r;
  assign bus.error = error_r;

endmodule

// File: tb/tb_mem_responder_sram.sv
// Scoreboard bench for mem_responder_sram: three instances (LATENCY 2, 1, 7),
// driven one at a time; a reference memory computes each expected response,
// which a negedge monitor matches against every resp pulse.
module tb_mem_responder_sram;

  localparam int LAT [3] = '{2, 1, 7};

  typedef struct {
    int          k;
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a   [3];
  logic [31:0] addr_a  [3];
  logic [3:0]  rmask_a [3];
  logic [3:0]  wmask_a [3];
  logic [31:0] wdata_a [3];
  logic [31:0] rdata_a [3];
  logic        resp_a  [3];
  logic        error_a [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder_sram_if bus_if ();
    assign bus_if.addr  = addr_a[g];
    assign bus_if.rmask = rmask_a[g];
    assign bus_if.wmask = wmask_a[g];
    assign bus_if.wdata = wdata_a[g];
    assign rdata_a[g]   = bus_if.rdata;
    assign resp_a[g]    = bus_if.resp;
    assign error_a[g]   = bus_if.error;
    mem_responder_sram #(.DEPTH_LOG2(10), .LATENCY(LAT[g])) u_dut (
      .clk (clk),
      .rst (rst_a[g]),
      .bus (bus_if.slave)
    );
  end

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [31:0] mdl [3][1024];
  logic        err_m [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  // Monitor: every resp must match the oldest expected entry; idle rdata is zero.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (resp_a[k]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: inst %0d pulsed resp at cycle %0d, none required", k, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_inst", 32'(k), 32'(mon_e.k));
          chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("rdata", rdata_a[k], mon_e.data);
          chk("error_at_resp", {31'd0, error_a[k]}, {31'd0, mon_e.err});
        end
      end else begin
        chk("rdata_idle", rdata_a[k], 32'h0);
      end
    end
  end

  // Issue one request on instance k (called at posedge+#1), hold it through resp.
  task automatic txn(input int k, input logic [31:0] a, input logic [3:0] rm,
                     input logic [3:0] wm, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] w;
    addr_a[k]  = a;
    rmask_a[k] = rm;
    wmask_a[k] = wm;
    wdata_a[k] = wd;
    if ((rm != 4'h0 && wm != 4'h0) || a[1:0] != 2'b00 || a >= 32'h1000) err_m[k] = 1'b1;
    w      = mdl[k][a[11:2]];
    e.k    = k;
    e.cyc  = cyc + LAT[k];
    e.err  = err_m[k];
    e.data = (rm != 4'h0 && wm == 4'h0) ? (w & lanes(rm)) : 32'h0;
    if (wm != 4'h0) mdl[k][a[11:2]] = (w & ~lanes(wm)) | (wd & lanes(wm));
    exp_q.push_back(e);
    repeat (LAT[k] + 1) @(posedge clk);
    #1;
    rmask_a[k] = 4'h0;
    wmask_a[k] = 4'h0;
  endtask

  task automatic pulse_reset(input int k);
    rst_a[k] = 1'b0;
    err_m[k] = 1'b0;
    #1;
    chk("rst_resp", {31'd0, resp_a[k]}, 32'h0);
    chk("rst_rdata", rdata_a[k], 32'h0);
    chk("rst_error", {31'd0, error_a[k]}, 32'h0);
    @(posedge clk);
    #1;
    rst_a[k] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Read of 0x10 on the LATENCY=7 instance with addr changed while waiting.
  task automatic mid_wait_change();
    exp_t e;
    addr_a[2]  = 32'h10;
    rmask_a[2] = 4'hF;
    wmask_a[2] = 4'h0;
    err_m[2]   = 1'b1;
    e.k    = 2;
    e.cyc  = cyc + 7;
    e.data = mdl[2][4];
    e.err  = 1'b1;
    exp_q.push_back(e);
    repeat (2) @(posedge clk);
    #1;
    addr_a[2] = 32'h14;
    repeat (6) @(posedge clk);
    #1;
    rmask_a[2] = 4'h0;
    addr_a[2]  = 32'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  m;
    for (int k = 0; k < 3; k++) begin
      rst_a[k] = 1'b0; addr_a[k] = 32'h0; rmask_a[k] = 4'h0;
      wmask_a[k] = 4'h0; wdata_a[k] = 32'h0; err_m[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_resp", {31'd0, resp_a[k]}, 32'h0);
      chk("reset_rdata", rdata_a[k], 32'h0);
      chk("reset_error", {31'd0, error_a[k]}, 32'h0);
      rst_a[k] = 1'b1;
    end
    @(posedge clk);
    #1;

    // Known contents for words 0..31 of every instance.
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 32; w++) txn(k, 32'(w * 4), 4'h0, 4'hF, $urandom);

    // Write then read, then partial lanes.
    txn(0, 32'h10, 4'h0, 4'hF, 32'hDEADBEEF);
    txn(0, 32'h10, 4'hF, 4'h0, 32'h0);
    txn(0, 32'h10, 4'h0, 4'b0101, 32'h11223344);
    txn(0, 32'h10, 4'b0011, 4'h0, 32'h0);

    // Random legal reads/writes on the LATENCY=2 instance.
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 31)) << 2;
      m = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 0) txn(0, a, m, 4'h0, 32'h0);
      else                           txn(0, a, 4'h0, m, $urandom);
    end

    // Latency sweep: 20 back-to-back reads at LATENCY 1 and 7.
    for (int k = 1; k < 3; k++)
      for (int i = 0; i < 20; i++)
        txn(k, 32'($urandom_range(0, 31)) << 2, 4'($urandom_range(1, 15)), 4'h0, 32'h0);

    // Protocol errors: each sets error, which then stays set.
    mid_wait_change();
    txn(2, 32'h18, 4'hF, 4'h0, 32'h0);
    pulse_reset(0);
    txn(0, 32'h40, 4'hF, 4'h1, 32'hA5A5A5A5);
    txn(0, 32'h40, 4'hF, 4'h0, 32'h0);
    pulse_reset(0);
    txn(0, 32'h13, 4'hF, 4'h0, 32'h0);
    txn(0, 32'h08, 4'hF, 4'h0, 32'h0);
    pulse_reset(0);
    txn(0, 32'h1010, 4'h0, 4'hC, 32'h77665544);
    txn(0, 32'h10, 4'hF, 4'h0, 32'h0);
    pulse_reset(0);

    // Reset during WAIT of a write: no resp, no commit.
    txn(0, 32'h20, 4'h0, 4'hF, 32'h12345678);
    addr_a[0]  = 32'h20;
    wmask_a[0] = 4'hF;
    wdata_a[0] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    wmask_a[0] = 4'h0;
    pulse_reset(0);
    txn(0, 32'h20, 4'hF, 4'h0, 32'h0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_pending", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
